// File: rtl/alarm_timer.sv
// alarm_timer
//   Countdown timer for the car-alarm FSM. On start_timer it loads a delay in
//   seconds from the time-parameter store and counts it down with an internal
//   divider that ticks once every CLK_FREQ clock cycles. When the count runs
//   out, expired pulses for one cycle.
//
// Optional feature macro: TIMER_PAUSE_EN (adds the hold input, which freezes
//   an in-flight countdown).
//
// Parameters
//   CLK_FREQ      clock cycles per second (divider period)
//   VALUE_W       width of value / seconds_left
//
// Ports
//   clk           system clock, all logic on posedge
//   reset_n       synchronous active-low reset
//   start_timer   1-cycle request: load value and (re)start the countdown
//   value         delay in seconds, sampled only with start_timer
//   hold          (TIMER_PAUSE_EN only) freeze the countdown while high
//   expired       registered 1-cycle pulse when the countdown finishes
//   busy          high while counting
//   seconds_left  remaining whole seconds
//   one_hz_enable registered 1-cycle tick once per second while counting
//
// State table
//   IDLE  | no countdown in progress, divider held at 0
//   COUNT | counting down seconds_left, divider running
module alarm_timer #(
  parameter int CLK_FREQ = 27_000_000,
  parameter int VALUE_W  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_timer,
  input  logic [VALUE_W-1:0] value,
`ifdef TIMER_PAUSE_EN
  input  logic               hold,
`endif
  output logic               expired,
  output logic               busy,
  output logic [VALUE_W-1:0] seconds_left,
  output logic               one_hz_enable
);

  localparam int DIV_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_FREQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   divider, divider_nxt;
  logic [VALUE_W-1:0] seconds_nxt;
  logic               expired_nxt;
  logic               zero_pend, zero_pend_nxt;
  logic               tick;
  logic               frozen;

`ifdef TIMER_PAUSE_EN
  assign frozen = hold;
`else
  assign frozen = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    divider_nxt   = divider;
    seconds_nxt   = seconds_left;
    // A zero-length start reports expiry one cycle after it was accepted.
    expired_nxt   = zero_pend;
    zero_pend_nxt = 1'b0;
    tick          = 1'b0;

    if (start_timer) begin
      // A restart discards any in-flight count, including a coincident final tick.
      seconds_nxt   = value;
      divider_nxt   = '0;
      zero_pend_nxt = (value == '0);
      state_nxt     = (value == '0) ? IDLE : COUNT;
    end else if (state == COUNT && !frozen) begin
      if (divider == DIV_MAX) begin
        tick        = 1'b1;
        divider_nxt = '0;
        if (seconds_left <= VALUE_W'(1)) begin
          seconds_nxt = '0;
          state_nxt   = IDLE;
          expired_nxt = 1'b1;
        end else begin
          seconds_nxt = seconds_left - VALUE_W'(1);
        end
      end else begin
        divider_nxt = divider + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      divider       <= '0;
      seconds_left  <= '0;
      expired       <= 1'b0;
      zero_pend     <= 1'b0;
      one_hz_enable <= 1'b0;
    end else begin
      state         <= state_nxt;
      divider       <= divider_nxt;
      seconds_left  <= seconds_nxt;
      expired       <= expired_nxt;
      zero_pend     <= zero_pend_nxt;
      one_hz_enable <= tick;
    end
  end

  assign busy = (state == COUNT);

endmodule

// File: tb/tb_alarm_timer.sv
module tb_alarm_timer;

  localparam int CLK_FREQ = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_timer = 1'b0;
  logic [3:0] value = 4'd0;
  logic       hold = 1'b0;
  logic       expired;
  logic       busy;
  logic [3:0] seconds_left;
  logic       one_hz_enable;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic       exp;
    logic       hz;
    logic [3:0] sl;
  } ev_t;

  ev_t q[$];

  alarm_timer #(.CLK_FREQ(CLK_FREQ), .VALUE_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_timer  (start_timer),
    .value        (value),
`ifdef TIMER_PAUSE_EN
    .hold         (hold),
`endif
    .expired      (expired),
    .busy         (busy),
    .seconds_left (seconds_left),
    .one_hz_enable(one_hz_enable)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push(input int c, input logic e, input logic h, input logic [3:0] s);
    ev_t ev;
    ev.cyc = c;
    ev.exp = e;
    ev.hz  = h;
    ev.sl  = s;
    q.push_back(ev);
  endfunction

  // Monitor: every output event is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (reset_n) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missed_event: no output event at cycle %0d (now %0d)", q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (one_hz_enable || expired) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: expired=%0b one_hz=%0b at cycle %0d, none expected",
                   expired, one_hz_enable, cyc);
        end else begin
          ev_t e;
          e = q.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("expired", expired, e.exp);
          check("one_hz_enable", one_hz_enable, e.hz);
          check("seconds_left", seconds_left, e.sl);
          check("busy_at_event", busy, !e.exp);
        end
      end
    end
  end

  // Called at a negedge; start takes effect at the next posedge, returned as e0.
  task automatic start(input logic [3:0] v, output int e0);
    start_timer = 1'b1;
    value       = v;
    e0          = cyc + 1;
    @(negedge clk);
    start_timer = 1'b0;
    value       = 4'($urandom);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (q.size() > 0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d events still pending after %0d cycles", q.size(), limit);
      q.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int e0, e1;

    // 1: reset dominates start_timer
    reset_n     = 1'b0;
    start_timer = 1'b1;
    value       = 4'd5;
    repeat (2) @(negedge clk);
    check("reset_expired", expired, 0);
    check("reset_busy", busy, 0);
    check("reset_seconds_left", seconds_left, 0);
    check("reset_one_hz", one_hz_enable, 0);
    start_timer = 1'b0;
    reset_n     = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_busy", busy, 0);

    // 2: value=3, value bus scrambled during count
    start(4'd3, e0);
    check("count3_busy", busy, 1);
    check("count3_loaded", seconds_left, 3);
    push(e0 + 10, 1'b0, 1'b1, 4'd2);
    push(e0 + 20, 1'b0, 1'b1, 4'd1);
    push(e0 + 30, 1'b1, 1'b1, 4'd0);
    wait_until(e0 + 9);
    check("count3_before_tick", seconds_left, 3);
    drain(60);
    check("count3_idle_busy", busy, 0);

    // 3: zero-length start
    start(4'd0, e0);
    push(e0 + 1, 1'b1, 1'b0, 4'd0);
    check("zero_busy_e0", busy, 0);
    @(negedge clk);
    check("zero_busy_e1", busy, 0);
    drain(10);

    // repeated zero starts give back-to-back pulses
    start(4'd0, e0);
    start(4'd0, e1);
    push(e0 + 1, 1'b1, 1'b0, 4'd0);
    push(e1 + 1, 1'b1, 1'b0, 4'd0);
    drain(10);

    // 4: restart overrides in-flight count
    start(4'd6, e0);
    push(e0 + 10, 1'b0, 1'b1, 4'd5);
    push(e0 + 20, 1'b0, 1'b1, 4'd4);
    wait_until(e0 + 24);
    start(4'd2, e1);
    push(e1 + 10, 1'b0, 1'b1, 4'd1);
    push(e1 + 20, 1'b1, 1'b1, 4'd0);
    drain(80);
    wait_until(e0 + 65);

    // start coincident with the final tick: start wins, no expiry
    start(4'd1, e0);
    wait_until(e0 + 9);
    start(4'd2, e1);
    check("coincident_reload", seconds_left, 2);
    push(e1 + 10, 1'b0, 1'b1, 4'd1);
    push(e1 + 20, 1'b1, 1'b1, 4'd0);
    drain(40);

    // 5: reset mid-count
    start(4'd4, e0);
    push(e0 + 10, 1'b0, 1'b1, 4'd3);
    wait_until(e0 + 14);
    reset_n = 1'b0;
    @(negedge clk);
    check("midreset_expired", expired, 0);
    check("midreset_busy", busy, 0);
    check("midreset_seconds_left", seconds_left, 0);
    check("midreset_one_hz", one_hz_enable, 0);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    check("midreset_queue_empty", q.size(), 0);

`ifdef TIMER_PAUSE_EN
    // 6: hold freezes the count for 7 cycles
    start(4'd2, e0);
    wait_until(e0 + 4);
    hold = 1'b1;
    wait_until(e0 + 11);
    hold = 1'b0;
    check("hold_frozen_seconds", seconds_left, 2);
    push(e0 + 17, 1'b0, 1'b1, 4'd1);
    push(e0 + 27, 1'b1, 1'b1, 4'd0);
    drain(40);
`endif

    check("final_queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
